seq_detect_prog: RTL
====================

// Module: seq_detect_prog
// PURPOSE
//  Programmable serial bit-pattern detector; parametrised successor to the fixed 8-state Mealy
//  detector for 01010101. Pattern, length (1..MAX_LEN) and overlap mode are loaded at run time.
//  Adds a qualifying enable, an armed status and a saturating match counter.
//  Sits on a 1-bit serial stream; flag feeds downstream framing/interrupt logic.
// PARAMETERS
//  MAX_LEN      8             longest detectable pattern, >= 2
//  CNT_W        16            match counter width
//  DEF_PATTERN  8'b0101_0101  pattern after reset (MAX_LEN bits)
//  DEF_LEN      8             length after reset
//  DEF_OVERLAP  1             overlap mode after reset
//  LEN_W (localparam) = $clog2(MAX_LEN)+1
// PORTS
//  clk          in   1        single clock, all logic on posedge
//  rst_n        in   1        reset, synchronous, active-low
//  en           in   1        din qualifier; bit sampled only when en=1
//  din          in   1        serial data bit
//  cfg_we       in   1        load cfg_* this edge
//  cfg_pattern  in   MAX_LEN  pattern; bit[len-1]=oldest, bit[0]=newest
//  cfg_len      in   LEN_W    pattern length; 0 -> 1, >MAX_LEN -> MAX_LEN
//  cfg_overlap  in   1        1 = overlapping matches allowed
//  cnt_clr      in   1        clear match counter
//  flag         out  1        registered match pulse
//  armed        out  1        history holds >= len valid bits
//  match_cnt    out  CNT_W    number of matches, saturating
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): hist=0, fill=0, pat=DEF_PATTERN, len=DEF_LEN,
//    overlap=DEF_OVERLAP, flag=0, armed=0, match_cnt=0. Overrides all other inputs.
//  - State: hist[MAX_LEN-1:0] shift register, fill counter 0..MAX_LEN (saturates).
//  - Priority per edge: rst_n > cfg_we > en.
//  - Sample (en=1, cfg_we=0): hist_n={hist[MAX_LEN-2:0],din}; fill_n=min(fill+1,MAX_LEN).
//    match = (fill_n >= len) && ((hist_n ^ pat) & mask(len)) == 0, mask = low len bits set.
//  - flag <= match; high exactly one cycle after the edge sampling the completing bit,
//    low otherwise (incl. en=0 cycles). Latency 1 clk from sample edge.
//  - Overlap=1: fill unchanged by match (e.g. 0101 in 010101 hits at bits 4 and 6).
//    Overlap=0: on match fill<=0, so next match needs len fresh bits.
//  - en=0: hist, fill hold; flag<=0; gaps do not break a partial match.
//  - cfg_we=1: pat/len/overlap load; hist<=0, fill<=0, flag<=0; din that edge discarded.
//  - armed = (fill >= len), registered consistent with fill/len.
//  - match_cnt: +1 on match, saturates at all-ones; cnt_clr=1 -> 0 (clr wins over
//    simultaneous match). cfg_we does not clear counter.
//  - Unused pattern bits above len ignored.
// TESTING
//  1 reset, default cfg, en=1, stream 0101010101 -> flag after bit8 and bit10, cnt=2, armed=1 from bit8.
//  2 cfg overlap=0, same default pattern, 16-bit 0101... -> flag after bit8 and bit16 only, cnt=2.
//  3 cfg len=3 pat=3'b110, stream 1,1,0,1,1,0 -> flags after bits 3,6; len=0 cfg -> behaves as len 1.
//  4 default pattern with en=0 gaps of 1-3 cycles between bits -> flag once after 8th sampled bit, 0 in gaps.
//  5 7 bits of 0101010 then cfg_we (same cfg), then din=1 -> no flag, armed=0; rst_n low mid-stream -> all regs reset.
//  6 CNT_W=2, 4 matches -> cnt 1,2,3,3; cnt_clr with concurrent match -> cnt=0, flag still 1.

Source files
------------

// File: rtl/seq_detect_prog.sv
// rtl/seq_detect_prog.sv - programmable serial bit-pattern detector with match counter
module seq_detect_prog #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 CNT_W       = 16,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = 8'b0101_0101,
    parameter int                 DEF_LEN     = 8,
    parameter bit                 DEF_OVERLAP = 1'b1,
    localparam int                LEN_W       = $clog2(MAX_LEN) + 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_en,
    input  logic               i_din,
    input  logic               i_cfg_we,
    input  logic [MAX_LEN-1:0] i_cfg_pattern,
    input  logic [LEN_W-1:0]   i_cfg_len,
    input  logic               i_cfg_overlap,
    input  logic               i_cnt_clr,
    output logic               o_flag,
    output logic               o_armed,
    output logic [CNT_W-1:0]   o_match_cnt
);

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] DEF_LEN_L = LEN_W'(DEF_LEN);
    localparam logic [LEN_W-1:0] ONE_L     = LEN_W'(1);

    logic [MAX_LEN-1:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic [MAX_LEN-1:0] r_pat;
    logic [LEN_W-1:0]   r_len;
    logic               r_overlap;
    logic               r_flag;
    logic               r_armed;
    logic [CNT_W-1:0]   r_cnt;

    logic [LEN_W-1:0]   w_cfg_len_eff;
    logic [MAX_LEN-1:0] w_hist_n;
    logic [LEN_W-1:0]   w_fill_n;
    logic [MAX_LEN-1:0] w_mask;
    logic               w_match;
    logic               w_cnt_max;

    // Clamp the requested length into 1..MAX_LEN so the stored length is always usable
    always_comb begin
        w_cfg_len_eff = i_cfg_len;
        if (i_cfg_len == '0) begin
            w_cfg_len_eff = ONE_L;
        end else if (i_cfg_len > MAX_LEN_L) begin
            w_cfg_len_eff = MAX_LEN_L;
        end
    end

    // Low r_len bits of the history take part in the compare; upper pattern bits are ignored
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (LEN_W'(i) < r_len);
        end
    end

    assign w_hist_n  = {r_hist[MAX_LEN-2:0], i_din};
    assign w_fill_n  = (r_fill == MAX_LEN_L) ? r_fill : r_fill + ONE_L;
    // Only a genuine sample edge can produce a match; cfg loads discard din
    assign w_match   = i_en && !i_cfg_we && (w_fill_n >= r_len)
                       && (((w_hist_n ^ r_pat) & w_mask) == '0);
    assign w_cnt_max = &r_cnt;

    // Shift history, track valid-bit fill level, and register flag/armed
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_hist    <= '0;
            r_fill    <= '0;
            r_pat     <= DEF_PATTERN;
            r_len     <= DEF_LEN_L;
            r_overlap <= DEF_OVERLAP;
            r_flag    <= 1'b0;
            r_armed   <= 1'b0;
        end else if (i_cfg_we) begin
            r_pat     <= i_cfg_pattern;
            r_len     <= w_cfg_len_eff;
            r_overlap <= i_cfg_overlap;
            r_hist    <= '0;
            r_fill    <= '0;
            r_flag    <= 1'b0;
            r_armed   <= 1'b0;
        end else if (i_en) begin
            r_hist <= w_hist_n;
            r_flag <= w_match;
            if (w_match && !r_overlap) begin
                // Non-overlapping: next hit must be built from len fresh bits
                r_fill  <= '0;
                r_armed <= 1'b0;
            end else begin
                r_fill  <= w_fill_n;
                r_armed <= (w_fill_n >= r_len);
            end
        end else begin
            r_flag <= 1'b0;
        end
    end

    // Saturating match counter; clear beats a simultaneous match, cfg loads leave it alone
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_cnt_clr) begin
            r_cnt <= '0;
        end else if (w_match && !w_cnt_max) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_flag      = r_flag;
    assign o_armed     = r_armed;
    assign o_match_cnt = r_cnt;

endmodule
